detector_ganador: RTL

// - Sequential win/draw detector for the 3x3 tic-tac-toe board; directly upstream of the winner-text sprite mux.
// - On start, snapshots the board and scans the 8 lines at one line per clock.
// - Drives registered gano/empate/ganador that the sprite mux consumes unchanged.

---
 rtl/juego_pkg.sv | 39 +++
 rtl/comparador_linea.sv | 15 +
 rtl/detector_ganador.sv | 123 ++++++++++++
 3 files changed

// File: rtl/juego_pkg.sv
// Shared types and constants for the tic-tac-toe win/draw detector.
// Holds the line table, the cell encoding and the FSM states.
package juego_pkg;

    typedef enum logic [1:0] {
        VACIA = 2'd0,
        JUG_X = 2'd1,
        JUG_O = 2'd2
    } celda_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } estado_t;

    localparam int N_LINEAS = 8;

    // Cell triples in scan order: rows, columns, diagonal, anti-diagonal.
    localparam int unsigned LINEAS [N_LINEAS][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic celda_t celda(input logic [17:0] tab, input int unsigned i);
        return celda_t'(tab[2*i +: 2]);
    endfunction

    // Encoding 3 counts as empty, so a cell is only occupied when it holds X or O.
    function automatic logic lleno(input logic [17:0] tab);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (!(tab[2*i +: 2] == 2'd1 || tab[2*i +: 2] == 2'd2)) r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/comparador_linea.sv
// Combinational check of one board line: three equal cells holding X or O.
module comparador_linea
    import juego_pkg::*;
(
    input  celda_t      a,
    input  celda_t      b,
    input  celda_t      c,
    output logic        hit,
    output logic [1:0]  jugador
);

    assign hit     = (a == b) && (b == c) && (a == JUG_X || a == JUG_O);
    assign jugador = hit ? 2'(a) : 2'd0;

endmodule

// File: rtl/detector_ganador.sv
// Sequential win/draw detector: snapshots the board on start and scans one line per clock.
// Define DETECTOR_LINEA_EN to add the registered winning-line index output linea.
module detector_ganador
    import juego_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [17:0] tablero,
    output logic        busy,
    output logic        done,
    output logic        gano,
    output logic        empate,
    output logic [1:0]  ganador
`ifdef DETECTOR_LINEA_EN
    ,
    output logic [2:0]  linea
`endif
);

    estado_t     estado_q, estado_d;
    logic [2:0]  idx_q, idx_d;
    logic [17:0] tab_q, tab_d;
    logic        busy_d, done_d, gano_d, empate_d;
    logic [1:0]  ganador_d;
`ifdef DETECTOR_LINEA_EN
    logic [2:0]  linea_d;
`endif

    celda_t      c0, c1, c2;
    logic        hit;
    logic [1:0]  jugador;

    assign c0 = celda(tab_q, LINEAS[idx_q][0]);
    assign c1 = celda(tab_q, LINEAS[idx_q][1]);
    assign c2 = celda(tab_q, LINEAS[idx_q][2]);

    comparador_linea u_comparador (
        .a       (c0),
        .b       (c1),
        .c       (c2),
        .hit     (hit),
        .jugador (jugador)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        estado_d  = estado_q;
        idx_d     = idx_q;
        tab_d     = tab_q;
        busy_d    = busy;
        done_d    = 1'b0;
        gano_d    = gano;
        empate_d  = empate;
        ganador_d = ganador;
`ifdef DETECTOR_LINEA_EN
        linea_d   = linea;
`endif
        case (estado_q)
            IDLE: begin
                if (start) begin
                    tab_d    = tablero;
                    idx_d    = 3'd0;
                    busy_d   = 1'b1;
                    estado_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    gano_d    = 1'b1;
                    ganador_d = jugador;
                    empate_d  = 1'b0;
`ifdef DETECTOR_LINEA_EN
                    linea_d   = idx_q;
`endif
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    estado_d  = IDLE;
                end else if (idx_q == 3'(N_LINEAS - 1)) begin
                    gano_d    = 1'b0;
                    ganador_d = 2'd0;
                    empate_d  = lleno(tab_q);
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    estado_d  = IDLE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q <= IDLE;
            idx_q    <= 3'd0;
            // NOTE: the snapshot is reset too; it is only a few flops and keeps the scan path free of X after reset.
            tab_q    <= 18'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            gano     <= 1'b0;
            empate   <= 1'b0;
            ganador  <= 2'd0;
`ifdef DETECTOR_LINEA_EN
            linea    <= 3'd0;
`endif
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            tab_q    <= tab_d;
            busy     <= busy_d;
            done     <= done_d;
            gano     <= gano_d;
            empate   <= empate_d;
            ganador  <= ganador_d;
`ifdef DETECTOR_LINEA_EN
            linea    <= linea_d;
`endif
        end
    end

endmodule
